tlk_link_ctrl: RTL and testbench
================================

// Module: tlk_link_ctrl
// PURPOSE
//   Bring-up and supervision sequencer for one TLK SERDES link on the SFP test board.
//   Powers the transceiver up and waits for lock (falling edge of tlk_err), then a settle period.
//   Then it asserts dval to the downstream data path.
//   Re-runs the sequence after sustained link errors or a lock timeout, and counts relock events.
// PARAMETERS
//   RST_CYCLES     64     cycles tlk_enable/tlk_lckrefn held low in PWRUP
//   SETTLE_CYCLES  1000   error-free cycles after lock before dval rises
//   LOCK_TIMEOUT   65535  max cycles in ACQUIRE before forced relock
//   ERR_TOL        4      consecutive tlk_err=1 cycles in LINKED that drop the link
// PORTS
//   clk          in   1  system clock; all logic on rising edge
//   reset        in   1  asynchronous, active-high reset
//   LIVE         in   1  run enable; 0 forces OFF
//   tlk_err      in   1  TLK receive error / loss-of-sync, synchronous to clk
//   tlk_enable   out  1  TLK enable (1 = powered)
//   tlk_lckrefn  out  1  TLK lock-to-reference, active-low (0 = lock to refclk)
//   dval         out  1  link data valid
//   state        out  3  OFF=0 PWRUP=1 ACQUIRE=2 SETTLE=3 LINKED=4
//   relock_cnt   out  8  relock events since reset, saturates at 255
//   timeout      out  1  one-cycle pulse on ACQUIRE timeout
// BEHAVIOUR
//   Reset: state=OFF, tlk_enable=0, tlk_lckrefn=0, dval=0, relock_cnt=0, timeout=0.
//   Reset: internal timer=0, err_run=0, err_d=1.
//   All outputs registered. The cycle timer clears on every state entry.
//   tlk_enable and tlk_lckrefn are both 1 in ACQUIRE, SETTLE and LINKED; both are 0 otherwise.
//   LIVE=0 in any state: next edge -> OFF, dval=0, timer=0, err_run=0; relock_cnt kept.
//   LIVE=0 has priority over every other transition.
//   OFF: LIVE=1 -> PWRUP.
//   PWRUP: stays exactly RST_CYCLES cycles (leaves when timer==RST_CYCLES-1) -> ACQUIRE.
//   PWRUP: err_d is preset to 1 on that exit edge.
//   ACQUIRE: err_d<=tlk_err each cycle. Lock = (err_d==1 && tlk_err==0).
//     tlk_err already 0 in the first ACQUIRE cycle counts as lock.
//   ACQUIRE: lock -> SETTLE.
//   ACQUIRE: else timer==LOCK_TIMEOUT-1 -> PWRUP, timeout=1 for one cycle, relock_cnt+1.
//     Lock wins if both occur in the same cycle.
//   SETTLE: tlk_err=1 on any cycle -> ACQUIRE; err_d preset 1, no relock increment.
//   SETTLE: timer==SETTLE_CYCLES-1 with tlk_err=0 -> LINKED, dval=1 on that same edge.
//     dval therefore rises SETTLE_CYCLES edges after SETTLE entry.
//   LINKED: tlk_err=1 -> err_run+1; tlk_err=0 -> err_run=0.
//   LINKED: err_run reaches ERR_TOL -> PWRUP on that edge, with dval=0 and relock_cnt+1.
//   relock_cnt saturates at 255 and never wraps; only reset clears it.
//   Timer width = clog2(max(RST_CYCLES,SETTLE_CYCLES,LOCK_TIMEOUT)). No counter may wrap inside a state.
//   Reset asserted mid-sequence: immediate return to reset values, asynchronously.
//   Reset release: starts from OFF.
// TESTING (bench params RST_CYCLES=4 SETTLE_CYCLES=8 LOCK_TIMEOUT=20 ERR_TOL=3)
//   Normal bring-up: reset release, LIVE=1, tlk_err=1 until 3 cycles into ACQUIRE then 0 ->
//     tlk_enable rises 4 cycles after PWRUP entry; dval=1 exactly 8 cycles after SETTLE entry; relock_cnt=0.
//   Settle glitch: tlk_err=1 for 1 cycle at SETTLE cycle 5 -> state=2, dval stays 0.
//     Later clean lock -> dval 8 cycles after the new SETTLE entry.
//   Lock timeout: tlk_err held 1 -> after 20 ACQUIRE cycles timeout pulses once, state=1, relock_cnt=1.
//     Repeats every 24 cycles; relock_cnt holds 255 after 300 events.
//   Error tolerance in LINKED: tlk_err high 2 cycles -> dval stays 1, err_run clears.
//     tlk_err high 3 consecutive cycles -> dval=0, state=1, relock_cnt+1.
//   LIVE drop: LIVE=0 in LINKED -> next edge state=0, dval=0, tlk_enable=0, relock_cnt unchanged.
//     LIVE=1 again -> full sequence restarts.
//   Async reset mid-SETTLE: reset pulse between edges -> outputs at reset values before the next edge.

Source files
------------

// File: rtl/tlk_link_ctrl.sv
// Bring-up and supervision sequencer for one TLK SERDES link: power-up, lock
// acquisition, settle, then data-valid, with relock on timeout or sustained errors.
module tlk_link_ctrl #(
  parameter int RST_CYCLES    = 64,
  parameter int SETTLE_CYCLES = 1000,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int ERR_TOL       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       LIVE,
  input  logic       tlk_err,
  output logic       tlk_enable,
  output logic       tlk_lckrefn,
  output logic       dval,
  output logic [2:0] state,
  output logic [7:0] relock_cnt,
  output logic       timeout
);

  localparam int MAX_A   = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int MAX_CYC = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int EW      = (ERR_TOL > 0) ? $clog2(ERR_TOL + 1) : 1;

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_PWRUP   = 3'd1,
    S_ACQUIRE = 3'd2,
    S_SETTLE  = 3'd3,
    S_LINKED  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [EW-1:0] err_run_q, err_run_d;
  logic          err_dly_q, err_dly_d;
  logic          dval_q, dval_d;
  logic          en_q, en_d;
  logic          timeout_q, timeout_d;
  logic [7:0]    relock_q, relock_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_OFF;
      timer_q   <= '0;
      err_run_q <= '0;
      err_dly_q <= 1'b1;
      dval_q    <= 1'b0;
      en_q      <= 1'b0;
      timeout_q <= 1'b0;
      relock_q  <= 8'd0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      err_run_q <= err_run_d;
      err_dly_q <= err_dly_d;
      dval_q    <= dval_d;
      en_q      <= en_d;
      timeout_q <= timeout_d;
      relock_q  <= relock_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    err_run_d = err_run_q;
    err_dly_d = err_dly_q;
    dval_d    = dval_q;
    timeout_d = 1'b0;
    relock_d  = relock_q;
    if (!LIVE) begin
      state_d   = S_OFF;
      timer_d   = '0;
      err_run_d = '0;
      err_dly_d = 1'b1;
      dval_d    = 1'b0;
    end else begin
      case (state_q)
        S_OFF: begin
          state_d = S_PWRUP;
          timer_d = '0;
        end
        S_PWRUP: begin
          if (timer_q == TW'(RST_CYCLES - 1)) begin
            state_d   = S_ACQUIRE;
            timer_d   = '0;
            err_dly_d = 1'b1;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        S_ACQUIRE: begin
          err_dly_d = tlk_err;
          // Lock is the falling edge of tlk_err; it beats a simultaneous timeout.
          if (err_dly_q && !tlk_err) begin
            state_d = S_SETTLE;
            timer_d = '0;
          end else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
            state_d   = S_PWRUP;
            timer_d   = '0;
            timeout_d = 1'b1;
            if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        S_SETTLE: begin
          if (tlk_err) begin
            state_d   = S_ACQUIRE;
            timer_d   = '0;
            err_dly_d = 1'b1;
          end else if (timer_q == TW'(SETTLE_CYCLES - 1)) begin
            state_d = S_LINKED;
            timer_d = '0;
            dval_d  = 1'b1;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        S_LINKED: begin
          if (tlk_err) begin
            if (err_run_q == EW'(ERR_TOL - 1)) begin
              state_d   = S_PWRUP;
              timer_d   = '0;
              err_run_d = '0;
              dval_d    = 1'b0;
              if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
            end else begin
              err_run_d = err_run_q + EW'(1);
            end
          end else begin
            err_run_d = '0;
          end
        end
        default: state_d = S_OFF;
      endcase
    end
    en_d = (state_d == S_ACQUIRE) || (state_d == S_SETTLE) || (state_d == S_LINKED);
  end

  assign tlk_enable  = en_q;
  assign tlk_lckrefn = en_q;
  assign dval        = dval_q;
  assign state       = state_q;
  assign relock_cnt  = relock_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_tlk_link_ctrl.sv
// Bench for tlk_link_ctrl: directed bring-up, glitch, timeout, error, LIVE and
// async-reset scenarios, checked every cycle against a behavioural link model.
module tb_tlk_link_ctrl;

  localparam int P_RST = 4;
  localparam int P_SET = 8;
  localparam int P_TO  = 20;
  localparam int P_TOL = 3;

  localparam int OFF = 0, PWRUP = 1, ACQ = 2, SETTLE = 3, LINKED = 4;

  logic       clk;
  logic       reset;
  logic       LIVE;
  logic       tlk_err;
  logic       tlk_enable;
  logic       tlk_lckrefn;
  logic       dval;
  logic [2:0] state;
  logic [7:0] relock_cnt;
  logic       timeout;

  int n_cmp = 0;
  int n_bad = 0;

  tlk_link_ctrl #(
    .RST_CYCLES(P_RST), .SETTLE_CYCLES(P_SET), .LOCK_TIMEOUT(P_TO), .ERR_TOL(P_TOL)
  ) dut (
    .clk(clk), .reset(reset), .LIVE(LIVE), .tlk_err(tlk_err),
    .tlk_enable(tlk_enable), .tlk_lckrefn(tlk_lckrefn), .dval(dval),
    .state(state), .relock_cnt(relock_cnt), .timeout(timeout)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all(input string name, input int st, input int en,
                           input int dv, input int rc, input int to);
    check({name, ".state"}, int'(state), st);
    check({name, ".tlk_enable"}, int'(tlk_enable), en);
    check({name, ".tlk_lckrefn"}, int'(tlk_lckrefn), en);
    check({name, ".dval"}, int'(dval), dv);
    check({name, ".relock_cnt"}, int'(relock_cnt), rc);
    check({name, ".timeout"}, int'(timeout), to);
  endtask

  // behavioural model: tracks phase, cycles spent in it, and link history
  int m_state  = OFF;
  int m_age    = 0;
  int m_errs   = 0;
  int m_relock = 0;
  bit m_fresh    = 1'b1;
  bit m_last_err = 1'b1;
  bit m_dval     = 1'b0;
  bit m_to       = 1'b0;

  task automatic model_step(input bit live, input bit err);
    int nxt;
    nxt  = m_state;
    m_to = 1'b0;
    if (!live) begin
      nxt = OFF; m_dval = 1'b0; m_errs = 0;
    end else begin
      case (m_state)
        OFF:   nxt = PWRUP;
        PWRUP: if (m_age + 1 == P_RST) nxt = ACQ;
        ACQ: begin
          if (!err && (m_fresh || m_last_err)) nxt = SETTLE;
          else if (m_age + 1 == P_TO) begin
            nxt = PWRUP; m_to = 1'b1;
            m_relock = (m_relock < 255) ? m_relock + 1 : 255;
          end
          m_last_err = err;
          m_fresh    = 1'b0;
        end
        SETTLE: begin
          if (err) nxt = ACQ;
          else if (m_age + 1 == P_SET) begin nxt = LINKED; m_dval = 1'b1; end
        end
        LINKED: begin
          m_errs = err ? m_errs + 1 : 0;
          if (m_errs == P_TOL) begin
            nxt = PWRUP; m_dval = 1'b0; m_errs = 0;
            m_relock = (m_relock < 255) ? m_relock + 1 : 255;
          end
        end
        default: nxt = OFF;
      endcase
    end
    if (nxt != m_state) begin
      m_age = 0;
      if (nxt == ACQ) m_fresh = 1'b1;
    end else begin
      m_age++;
    end
    m_state = nxt;
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_state = OFF; m_age = 0; m_errs = 0; m_relock = 0;
        m_fresh = 1'b1; m_last_err = 1'b1; m_dval = 1'b0; m_to = 1'b0;
      end else begin
        model_step(LIVE, tlk_err);
      end
    end
  end

  // per-cycle compare against the model
  initial begin
    logic [14:0] act_v, exp_v;
    bit m_en;
    forever begin
      @(negedge clk);
      if (!reset) begin
        m_en  = (m_state == ACQ) || (m_state == SETTLE) || (m_state == LINKED);
        act_v = {state, tlk_enable, tlk_lckrefn, dval, timeout, relock_cnt};
        exp_v = {3'(m_state), m_en, m_en, m_dval, m_to, 8'(m_relock)};
        n_cmp++;
        if (act_v != exp_v) begin
          n_bad++;
          $display("FAIL model_cycle t=%0t: got st=%0d en=%0b lck=%0b dv=%0b to=%0b rc=%0d, expected st=%0d en=%0b dv=%0b to=%0b rc=%0d",
                   $time, state, tlk_enable, tlk_lckrefn, dval, timeout, relock_cnt,
                   m_state, m_en, m_dval, m_to, m_relock);
        end
      end
    end
  end

  // directed stimulus
  initial begin
    reset = 1'b1; LIVE = 1'b0; tlk_err = 1'b1;
    tick(3);
    check_all("reset", OFF, 0, 0, 0, 0);
    reset = 1'b0;
    tick(2);
    check_all("off_idle", OFF, 0, 0, 0, 0);

    // normal bring-up
    LIVE = 1'b1;
    tick(1);
    check_all("pwrup_entry", PWRUP, 0, 0, 0, 0);
    tick(3);
    check_all("pwrup_last", PWRUP, 0, 0, 0, 0);
    tick(1);
    check_all("acq_entry", ACQ, 1, 0, 0, 0);
    tick(3);
    check("acq_wait.state", int'(state), ACQ);
    tlk_err = 1'b0;
    tick(1);
    check_all("settle_entry", SETTLE, 1, 0, 0, 0);
    tick(7);
    check_all("settle_last", SETTLE, 1, 0, 0, 0);
    tick(1);
    check_all("linked", LINKED, 1, 1, 0, 0);

    // error tolerance in LINKED
    tlk_err = 1'b1; tick(2);
    tlk_err = 1'b0; tick(1);
    check_all("err2_hold", LINKED, 1, 1, 0, 0);
    tlk_err = 1'b1; tick(2);
    check_all("err_run_cleared", LINKED, 1, 1, 0, 0);
    tick(1);
    check_all("err3_drop", PWRUP, 0, 0, 1, 0);

    // settle glitch
    tlk_err = 1'b0;
    tick(4);
    check("relock_acq.state", int'(state), ACQ);
    tick(1);
    check("first_cycle_lock.state", int'(state), SETTLE);
    tick(5);
    tlk_err = 1'b1; tick(1);
    check_all("settle_glitch", ACQ, 1, 0, 1, 0);
    tlk_err = 1'b0; tick(1);
    check("relock_settle.state", int'(state), SETTLE);
    tick(7);
    check("settle2_last.dval", int'(dval), 0);
    tick(1);
    check_all("linked2", LINKED, 1, 1, 1, 0);

    // LIVE drop and restart into lock timeout
    LIVE = 1'b0; tick(1);
    check_all("live_drop", OFF, 0, 0, 1, 0);
    LIVE = 1'b1; tlk_err = 1'b1; tick(1);
    check("restart.state", int'(state), PWRUP);
    tick(4);
    check("to_acq.state", int'(state), ACQ);
    tick(19);
    check_all("to_last_acq", ACQ, 1, 0, 1, 0);
    tick(1);
    check_all("timeout1", PWRUP, 0, 0, 2, 1);
    tick(1);
    check("timeout_pulse_end", int'(timeout), 0);
    tick(23);
    check_all("timeout2", PWRUP, 0, 0, 3, 1);
    tick(24 * 297);
    check_all("relock_saturate", PWRUP, 0, 0, 255, 1);
    tick(24);
    check("relock_hold_255", int'(relock_cnt), 255);

    // async reset mid-SETTLE
    tlk_err = 1'b0;
    tick(4);
    tick(1);
    tick(2);
    check("pre_reset.state", int'(state), SETTLE);
    #2 reset = 1'b1;
    #1 check_all("async_reset", OFF, 0, 0, 0, 0);
    #1 reset = 1'b0;
    tick(1);
    check_all("after_reset", PWRUP, 0, 0, 0, 0);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
